// File: rtl/rx_packet_fifo.sv
// rx_packet_fifo: single-clock frame FIFO for the Ethernet receive path.
// Words are written speculatively behind a commit pointer. A good frame is
// published with wr_commit. A bad frame is rewound with wr_discard, or is
// dropped whole when it overflowed the storage. The read side is showahead,
// and the head word is held in a registered output stage.
module rx_packet_fifo #(
    parameter int WIDTH        = 16,
    parameter int DEPTH        = 512,
    parameter int AW           = $clog2(DEPTH),
    parameter int AFULL_THRESH = 480
) (
    input  logic             clk,
    input  logic             sclr,
    input  logic [WIDTH-1:0] data,
    input  logic             wrreq,
    input  logic             wr_commit,
    input  logic             wr_discard,
    input  logic             rdreq,
    output logic [WIDTH-1:0] q,
    output logic             rdempty,
    output logic             wrfull,
    output logic             almost_full,
    output logic [AW:0]      rdusedw,
    output logic [15:0]      drop_count,
    output logic             drop_pulse
);

    // Pointers carry one extra wrap bit so that full and empty can be told apart.
    typedef logic [AW:0] ptr_t;

    localparam ptr_t PTR_ONE = ptr_t'(1);
    localparam ptr_t DEPTH_P = ptr_t'(DEPTH);
    localparam ptr_t AFULL_P = ptr_t'(AFULL_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];

    ptr_t        wr_ptr_q, wr_ptr_d;     // speculative write pointer
    ptr_t        cm_ptr_q, cm_ptr_d;     // last commit point
    ptr_t        cm_vis_q;               // commit point as seen by the reader, one cycle later
    ptr_t        rd_ptr_q, rd_ptr_d;     // address of the word presented on q
    logic        ovf_q, ovf_d;           // current frame hit a full buffer
    logic [15:0] drop_count_q, drop_count_d;
    logic        drop_pulse_q, drop_pulse_d;
    logic [WIDTH-1:0] q_q;

    ptr_t used;
    logic pop;
    logic ovf_hit;
    logic wr_en;
    logic do_commit;
    logic do_drop;
    logic head_valid;

    // Occupancy flags are derived from the registered (post-edge) pointers.
    assign used        = wr_ptr_q - rd_ptr_q;
    assign wrfull      = (used == DEPTH_P);
    assign almost_full = (used >= AFULL_P);
    assign rdusedw     = cm_vis_q - rd_ptr_q;
    assign rdempty     = (cm_vis_q == rd_ptr_q);

    assign pop         = rdreq & ~rdempty;
    // A write refused by wrfull in the same cycle as the commit still spoils the frame.
    assign ovf_hit     = ovf_q | (wrreq & wrfull);
    // A word that arrives in the same cycle as a discard belongs to the bad frame, so it is not stored.
    assign wr_en       = wrreq & ~wrfull & ~ovf_q & ~wr_discard;
    assign do_commit   = wr_commit & ~wr_discard & ~ovf_hit;
    assign do_drop     = wr_commit & ~wr_discard & ovf_hit;
    // After this edge, the reader has a word if the commit point runs ahead of the next read pointer.
    assign head_valid  = (cm_ptr_q != rd_ptr_d);

    // Next-state logic for the pointers, the overflow flag and the drop statistics.
    always_comb begin
        // NOTE: every signal gets a default first so that no path leaves it unassigned (no latch).
        wr_ptr_d     = wr_ptr_q;
        cm_ptr_d     = cm_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        ovf_d        = ovf_q;
        drop_count_d = drop_count_q;
        drop_pulse_d = 1'b0;

        if (wr_discard || do_drop) begin
            wr_ptr_d = cm_ptr_q;
        end else if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        if (do_commit) begin
            cm_ptr_d = wr_en ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        end

        if (wr_commit || wr_discard) begin
            ovf_d = 1'b0;
        end else if (wrreq && wrfull) begin
            ovf_d = 1'b1;
        end

        if (do_drop) begin
            drop_pulse_d = 1'b1;
            if (drop_count_q != 16'hFFFF) begin
                drop_count_d = drop_count_q + 16'd1;
            end
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
        if (sclr) begin
            wr_ptr_q     <= '0;
            cm_ptr_q     <= '0;
            cm_vis_q     <= '0;
            rd_ptr_q     <= '0;
            ovf_q        <= 1'b0;
            drop_count_q <= '0;
            drop_pulse_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            cm_ptr_q     <= cm_ptr_d;
            cm_vis_q     <= cm_ptr_q;
            rd_ptr_q     <= rd_ptr_d;
            ovf_q        <= ovf_d;
            drop_count_q <= drop_count_d;
            drop_pulse_q <= drop_pulse_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the data array is deliberately not reset; the pointers alone decide which words are valid.
        if (wr_en && !sclr) begin
            mem[wr_ptr_q[AW-1:0]] <= data;
        end
    end

    // Registered read port: prefetch the head word; hold q while nothing is available.
    always_ff @(posedge clk) begin
        if (sclr) begin
            q_q <= '0;
        end else if (head_valid) begin
            q_q <= mem[rd_ptr_d[AW-1:0]];
        end
    end

    assign q          = q_q;
    assign drop_count = drop_count_q;
    assign drop_pulse = drop_pulse_q;

endmodule

// File: tb/tb_rx_packet_fifo.sv
// Self-checking bench for rx_packet_fifo (DEPTH=16, AFULL_THRESH=12).
// A queue-based frame model updates on every rising edge. A compare process
// checks all outputs on every falling edge. Directed sequences add literal
// expectations at the key points.
module tb_rx_packet_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int AFULL = 12;

    logic             clk;
    logic             sclr;
    logic [WIDTH-1:0] data;
    logic             wrreq;
    logic             wr_commit;
    logic             wr_discard;
    logic             rdreq;
    logic [WIDTH-1:0] q;
    logic             rdempty;
    logic             wrfull;
    logic             almost_full;
    logic [AW:0]      rdusedw;
    logic [15:0]      drop_count;
    logic             drop_pulse;

    int checks = 0;
    int errors = 0;

    rx_packet_fifo #(
        .WIDTH        (WIDTH),
        .DEPTH        (DEPTH),
        .AW           (AW),
        .AFULL_THRESH (AFULL)
    ) dut (
        .clk         (clk),
        .sclr        (sclr),
        .data        (data),
        .wrreq       (wrreq),
        .wr_commit   (wr_commit),
        .wr_discard  (wr_discard),
        .rdreq       (rdreq),
        .q           (q),
        .rdempty     (rdempty),
        .wrfull      (wrfull),
        .almost_full (almost_full),
        .rdusedw     (rdusedw),
        .drop_count  (drop_count),
        .drop_pulse  (drop_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Frame model: committed words, open-frame words, visibility delay.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] m_fifo[$];   // committed, unread words (oldest first)
    logic [WIDTH-1:0] m_pend[$];   // words of the frame currently being written
    int               m_fresh;     // words committed at the last edge, not yet visible
    bit               m_ovf;
    int               m_drops;
    bit               m_pulse;
    logic [WIDTH-1:0] m_q;
    bit               m_started = 0;

    function automatic int m_vis();
        return m_fifo.size() - m_fresh;
    endfunction

    function automatic int m_used();
        return m_fifo.size() + m_pend.size();
    endfunction

    always @(posedge clk) begin
        bit full;
        bit hit;
        m_started = 1;
        if (sclr) begin
            m_fifo.delete();
            m_pend.delete();
            m_fresh = 0;
            m_ovf   = 0;
            m_drops = 0;
            m_pulse = 0;
            m_q     = '0;
        end else begin
            full = (m_used() == DEPTH);
            hit  = m_ovf || (wrreq && full);
            if (rdreq && m_vis() > 0) void'(m_fifo.pop_front());
            m_fresh = 0;
            m_pulse = 0;
            if (wr_discard) begin
                m_pend.delete();
                m_ovf = 0;
            end else begin
                if (wrreq && !full && !m_ovf) m_pend.push_back(data);
                if (wr_commit) begin
                    if (hit) begin
                        m_pend.delete();
                        m_pulse = 1;
                        if (m_drops < 65535) m_drops++;
                    end else begin
                        m_fresh = m_pend.size();
                        foreach (m_pend[i]) m_fifo.push_back(m_pend[i]);
                        m_pend.delete();
                    end
                    m_ovf = 0;
                end else if (wrreq && full) begin
                    m_ovf = 1;
                end
            end
            if (m_vis() > 0) m_q = m_fifo[0];
        end
    end

    // Compare every output against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_started) begin
            check("rdempty",     rdempty,     (m_vis() == 0));
            check("rdusedw",     rdusedw,     m_vis());
            check("q",           q,           m_q);
            check("wrfull",      wrfull,      (m_used() == DEPTH));
            check("almost_full", almost_full, (m_used() >= AFULL));
            check("drop_count",  drop_count,  m_drops);
            check("drop_pulse",  drop_pulse,  m_pulse);
        end
    end

    // Pop counter for the wrap test; inputs and pre-edge rdempty are stable at the rising edge.
    bit count_pops = 0;
    int pops = 0;
    always @(posedge clk) begin
        if (count_pops && rdreq && !rdempty) pops++;
    end

    // Apply one cycle of inputs; return at the next falling edge.
    task automatic step(input bit s, input bit w, input logic [WIDTH-1:0] d,
                        input bit c, input bit x, input bit r);
        sclr       = s;
        wrreq      = w;
        data       = d;
        wr_commit  = c;
        wr_discard = x;
        rdreq      = r;
        @(negedge clk);
    endtask

    task automatic wr(input logic [WIDTH-1:0] d, input bit c, input bit r);
        step(1'b0, 1'b1, d, c, 1'b0, r);
    endtask

    task automatic idle(input bit r);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, r);
    endtask

    initial begin
        // 1: reset with write/read strobes toggling
        step(1'b1, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 16'h5678, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'h9ABC, 1'b1, 1'b0, 1'b1);
        check("rst_rdempty", rdempty, 1'b1);
        check("rst_wrfull", wrfull, 1'b0);
        check("rst_q", q, 16'h0000);
        check("rst_drop_count", drop_count, 16'h0000);
        idle(1'b1);
        check("rst_rdreq_ignored", rdempty, 1'b1);

        // 2: basic 4-word frame, commit with the last word
        wr(16'h0001, 1'b0, 1'b0);
        wr(16'h0002, 1'b0, 1'b0);
        wr(16'h0003, 1'b0, 1'b0);
        wr(16'h0004, 1'b1, 1'b0);
        check("basic_latency_empty", rdempty, 1'b1);
        idle(1'b0);
        check("basic_rdempty", rdempty, 1'b0);
        check("basic_q", q, 16'h0001);
        check("basic_rdusedw", rdusedw, 5'd4);
        check("model_vis_pin", m_vis(), 4);
        idle(1'b1);
        check("basic_pop1_q", q, 16'h0002);
        idle(1'b1);
        idle(1'b1);
        check("basic_pop3_q", q, 16'h0004);
        check("basic_pop3_used", rdusedw, 5'd1);
        idle(1'b1);
        check("basic_drained", rdempty, 1'b1);
        check("basic_q_hold", q, 16'h0004);

        // 3: discard then a good 2-word frame
        wr(16'h00AA, 1'b0, 1'b0);
        wr(16'h00AA, 1'b0, 1'b0);
        wr(16'h00AA, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        idle(1'b0);
        idle(1'b0);
        check("disc_rdempty", rdempty, 1'b1);
        check("disc_drop_count", drop_count, 16'h0000);
        wr(16'h0B0B, 1'b0, 1'b0);
        wr(16'h0B0B, 1'b1, 1'b0);
        idle(1'b0);
        check("disc_rdusedw", rdusedw, 5'd2);
        check("disc_q", q, 16'h0B0B);
        idle(1'b1);
        idle(1'b1);
        check("disc_drained", rdempty, 1'b1);

        // 4: 20-word frame overflows the 16-word store and is dropped on commit
        for (int i = 1; i <= 20; i++) begin
            wr(16'h4000 + 16'(i), 1'b0, 1'b0);
            if (i == 11) check("ovf_af_11", almost_full, 1'b0);
            if (i == 12) check("ovf_af_12", almost_full, 1'b1);
            if (i == 15) check("ovf_full_15", wrfull, 1'b0);
            if (i == 16) check("ovf_full_16", wrfull, 1'b1);
        end
        check("ovf_still_full", wrfull, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("ovf_pulse", drop_pulse, 1'b1);
        check("ovf_count", drop_count, 16'h0001);
        check("ovf_rdempty", rdempty, 1'b1);
        check("ovf_wrfull_clr", wrfull, 1'b0);
        idle(1'b0);
        check("ovf_pulse_once", drop_pulse, 1'b0);
        check("model_drops_pin", m_drops, 1);
        wr(16'h4A01, 1'b0, 1'b0);
        wr(16'h4A02, 1'b1, 1'b0);
        idle(1'b0);
        check("ovf_next_q", q, 16'h4A01);
        idle(1'b1);
        check("ovf_next_q2", q, 16'h4A02);
        idle(1'b1);
        check("ovf_next_drained", rdempty, 1'b1);

        // 5: five 7-word frames with a concurrent reader; pointers wrap
        count_pops = 1;
        for (int f = 0; f < 5; f++) begin
            for (int k = 0; k < 7; k++) begin
                wr(16'h5000 + 16'(f * 7 + k), (k == 6), 1'b1);
            end
        end
        for (int i = 0; i < 12; i++) idle(1'b1);
        count_pops = 0;
        check("wrap_pops", pops, 35);
        check("wrap_drained", rdempty, 1'b1);
        check("wrap_last_q", q, 16'h5022);
        wr(16'h0C01, 1'b0, 1'b0);
        wr(16'h0C02, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h0C03, 1'b1, 1'b1, 1'b0);
        idle(1'b0);
        idle(1'b0);
        check("cd_rdempty", rdempty, 1'b1);
        check("cd_rdusedw", rdusedw, 5'd0);
        check("cd_drop_count", drop_count, 16'h0001);

        // 6: reset mid-frame with committed words pending
        wr(16'h6001, 1'b0, 1'b0);
        wr(16'h6002, 1'b0, 1'b0);
        wr(16'h6003, 1'b1, 1'b0);
        idle(1'b0);
        check("mid_rdusedw", rdusedw, 5'd3);
        wr(16'h6004, 1'b0, 1'b0);
        wr(16'h6005, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'h6006, 1'b0, 1'b0, 1'b1);
        check("mid_rst_rdempty", rdempty, 1'b1);
        check("mid_rst_q", q, 16'h0000);
        check("mid_rst_rdusedw", rdusedw, 5'd0);
        check("mid_rst_drop_count", drop_count, 16'h0000);
        check("mid_rst_wrfull", wrfull, 1'b0);
        check("mid_rst_af", almost_full, 1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        check("mid_no_stale", rdempty, 1'b1);
        wr(16'h7001, 1'b0, 1'b0);
        wr(16'h7002, 1'b1, 1'b0);
        idle(1'b0);
        check("post_rst_q", q, 16'h7001);
        idle(1'b1);
        check("post_rst_q2", q, 16'h7002);
        idle(1'b1);
        idle(1'b0);
        check("post_rst_drained", rdempty, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
